i2c_reg_master: RTL and testbench

Single-transaction I2C master that drives the I2C slave register bank on the same board. It turns a one-cycle command from the local controller (register index, R/W, write byte) into a complete I2C frame on oSCL/ioSDA: START, device address + R/W, register-pointer byte, one data byte, STOP. Read data and status come back to the controller. The protocol is fixed to the slave's framing: the register-pointer byte is sent on reads as well, and there is no repeated START.

---
 rtl/i2c_reg_master_if.sv | 16 +
 rtl/i2c_reg_master.sv | 196 +++++++++++++++++++
 tb/tb_i2c_reg_master.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_master_if.sv
// Command/status bundle between the local controller and i2c_reg_master.
interface i2c_reg_master_if;
  logic       iStart;
  logic       iRw;
  logic [7:0] iRegAddr;
  logic [7:0] iWData;
  logic [7:0] oRData;
  logic       oBusy;
  logic       oDone;
  logic       oAckErr;

  modport master (output iStart, iRw, iRegAddr, iWData,
                  input  oRData, oBusy, oDone, oAckErr);
  modport slave  (input  iStart, iRw, iRegAddr, iWData,
                  output oRData, oBusy, oDone, oAckErr);
endinterface

// File: rtl/i2c_reg_master.sv
// Single-transaction I2C master: START, addr+R/W, reg pointer, one data byte, STOP.
// Optional I2C_MST_ACK_CHK_EN: abort to STOP on NACK and report it on oAckErr.
module i2c_reg_master #(
  parameter logic [6:0] SLAVE_ADDR = 7'h54,
  parameter int         QTR_CYCLES = 250
) (
  input  logic             iClk,
  input  logic             iRst,
  i2c_reg_master_if.slave  cmd,
  output logic             oSCL,
  inout  wire              ioSDA
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_ADDR     = 4'd2;
  localparam logic [3:0] S_ADDR_ACK = 4'd3;
  localparam logic [3:0] S_REG      = 4'd4;
  localparam logic [3:0] S_REG_ACK  = 4'd5;
  localparam logic [3:0] S_WDATA    = 4'd6;
  localparam logic [3:0] S_WACK     = 4'd7;
  localparam logic [3:0] S_RDATA    = 4'd8;
  localparam logic [3:0] S_RNACK    = 4'd9;
  localparam logic [3:0] S_STOP     = 4'd10;

  localparam int QW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;

  logic [3:0]    state_q, state_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          rw_q, rw_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          done_q, done_d;
  logic          scl_q, scl_d;
  logic          sda_oe_q, sda_oe_d;
  logic [7:0]    tx_d;
  logic          qtr_last;
  logic          sda_in;
  logic          abort;

`ifdef I2C_MST_ACK_CHK_EN
  logic nack_q, nack_d;
  logic ackerr_q, ackerr_d;
  assign abort = nack_q;
`else
  assign abort = 1'b0;
`endif

  assign sda_in   = ioSDA;
  assign qtr_last = (qcnt_q == QW'(QTR_CYCLES - 1));

  // Bus levels for a given slot/quarter; evaluated on next-state so the pins are registered.
  function automatic logic [1:0] bus_drv(input logic [3:0] st, input logic [1:0] qtr,
                                         input logic [2:0] bitn, input logic [7:0] tx);
    logic scl, oe;
    scl = (qtr == 2'd1) || (qtr == 2'd2);
    oe  = 1'b0;
    case (st)
      S_IDLE:  scl = 1'b1;
      S_START: begin scl = (qtr != 2'd3); oe = (qtr != 2'd0); end
      S_STOP:  begin scl = (qtr != 2'd0); oe = (qtr < 2'd2);  end
      S_ADDR, S_REG, S_WDATA: oe = ~tx[3'd7 - bitn];
      default: oe = 1'b0;
    endcase
    return {scl, oe};
  endfunction

  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    qcnt_d  = qcnt_q;
    bit_d   = bit_q;
    rw_d    = rw_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
`ifdef I2C_MST_ACK_CHK_EN
    nack_d   = nack_q;
    ackerr_d = ackerr_q;
`endif
    if (state_q == S_IDLE) begin
      qcnt_d = '0;
      qtr_d  = '0;
      bit_d  = '0;
      if (cmd.iStart) begin
        state_d = S_START;
        rw_d    = cmd.iRw;
        reg_d   = cmd.iRegAddr;
        wdata_d = cmd.iWData;
`ifdef I2C_MST_ACK_CHK_EN
        nack_d  = 1'b0;
`endif
      end
    end else if (!qtr_last) begin
      qcnt_d = qcnt_q + 1'b1;
    end else begin
      qcnt_d = '0;
      qtr_d  = qtr_q + 2'd1;
      // Sample point: last cycle of q1, mid SCL-high.
      if (qtr_q == 2'd1) begin
        case (state_q)
          S_RDATA: shift_d = {shift_q[6:0], sda_in};
`ifdef I2C_MST_ACK_CHK_EN
          S_ADDR_ACK, S_REG_ACK, S_WACK: if (sda_in) nack_d = 1'b1;
`endif
          default: ;
        endcase
      end
      if (qtr_q == 2'd3) begin
        case (state_q)
          S_START:    state_d = S_ADDR;
          S_ADDR:     begin bit_d = bit_q + 3'd1; if (bit_q == 3'd7) state_d = S_ADDR_ACK; end
          S_ADDR_ACK: state_d = abort ? S_STOP : S_REG;
          S_REG:      begin bit_d = bit_q + 3'd1; if (bit_q == 3'd7) state_d = S_REG_ACK; end
          S_REG_ACK:  state_d = abort ? S_STOP : (rw_q ? S_RDATA : S_WDATA);
          S_WDATA:    begin bit_d = bit_q + 3'd1; if (bit_q == 3'd7) state_d = S_WACK; end
          S_WACK:     state_d = S_STOP;
          S_RDATA:    begin bit_d = bit_q + 3'd1; if (bit_q == 3'd7) state_d = S_RNACK; end
          S_RNACK:    begin rdata_d = shift_q; state_d = S_STOP; end
          S_STOP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
`ifdef I2C_MST_ACK_CHK_EN
            ackerr_d = nack_q;
`endif
          end
          default:    state_d = S_IDLE;
        endcase
      end
    end

    case (state_d)
      S_ADDR:  tx_d = {SLAVE_ADDR, rw_d};
      S_REG:   tx_d = reg_d;
      S_WDATA: tx_d = wdata_d;
      default: tx_d = 8'h00;
    endcase
    {scl_d, sda_oe_d} = bus_drv(state_d, qtr_d, bit_d, tx_d);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      qtr_q    <= '0;
      qcnt_q   <= '0;
      bit_q    <= '0;
      rw_q     <= 1'b0;
      reg_q    <= '0;
      wdata_q  <= '0;
      shift_q  <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
`ifdef I2C_MST_ACK_CHK_EN
      nack_q   <= 1'b0;
      ackerr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      qtr_q    <= qtr_d;
      qcnt_q   <= qcnt_d;
      bit_q    <= bit_d;
      rw_q     <= rw_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      shift_q  <= shift_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
`ifdef I2C_MST_ACK_CHK_EN
      nack_q   <= nack_d;
      ackerr_q <= ackerr_d;
`endif
    end
  end

  assign oSCL        = scl_q;
  assign ioSDA       = sda_oe_q ? 1'b0 : 1'bz;
  assign cmd.oRData  = rdata_q;
  assign cmd.oBusy   = (state_q != S_IDLE);
  assign cmd.oDone   = done_q;
`ifdef I2C_MST_ACK_CHK_EN
  assign cmd.oAckErr = ackerr_q;
`else
  assign cmd.oAckErr = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_reg_master.sv
// Bench for i2c_reg_master: behavioural register-bank slave at 7'h54 plus a
// scoreboard of expected oDone events checked by independent monitors.
module tb_i2c_reg_master;
  localparam int Q     = 4;
  localparam int FRAME = 116 * Q;
  localparam int BOUND = FRAME + 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_reg_master_if bus1 ();
  i2c_reg_master_if bus2 ();
  wire scl1, scl2;
  wire sda1, sda2;
  pullup (sda1);
  pullup (sda2);

  logic sl_drv = 1'b0;
  assign sda1 = sl_drv ? 1'b0 : 1'bz;

  i2c_reg_master #(.SLAVE_ADDR(7'h54), .QTR_CYCLES(Q)) u_dut (
    .iClk(clk), .iRst(rst), .cmd(bus1.slave), .oSCL(scl1), .ioSDA(sda1));

  // Mis-addressed master on a bus with only a pull-up: every ACK slot reads NACK.
  i2c_reg_master #(.SLAVE_ADDR(7'h55), .QTR_CYCLES(Q)) u_dut_bad (
    .iClk(clk), .iRst(rst), .cmd(bus2.slave), .oSCL(scl2), .ioSDA(sda2));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural slave (7'h54, 4 registers) ----------------
  logic [7:0] sl_reg [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic       sl_pscl = 1'b1, sl_psda = 1'b1;
  logic       sl_active = 1'b0, sl_rose = 1'b0, sl_match = 1'b0, sl_rw = 1'b0;
  logic       sl_mnack = 1'b0;
  logic [7:0] sl_shift = 8'h00, sl_tx = 8'h00;
  logic [1:0] sl_ptr = 2'd0;
  int         sl_bit = 0, sl_byte = 0, sl_starts = 0, sl_stops = 0;

  always @(scl1 or sda1) begin
    if (scl1 && !sl_pscl) begin
      if (sl_active) begin
        sl_rose = 1'b1;
        if (sl_bit < 8) sl_shift = {sl_shift[6:0], sda1};
        else if (sl_byte == 2 && sl_rw) sl_mnack = sda1;
      end
    end else if (!scl1 && sl_pscl) begin
      if (sl_active && sl_rose) begin
        if (sl_bit < 8) begin
          sl_bit++;
          if (sl_bit == 8) begin
            case (sl_byte)
              0: begin sl_match = (sl_shift[7:1] == 7'h54); sl_rw = sl_shift[0]; sl_drv = sl_match; end
              1: begin if (sl_match) sl_ptr = sl_shift[1:0]; sl_drv = sl_match; end
              2: begin
                if (sl_match && !sl_rw) sl_reg[sl_ptr] = sl_shift;
                sl_drv = sl_match && !sl_rw;
              end
              default: sl_drv = 1'b0;
            endcase
          end else if (sl_byte == 2 && sl_rw && sl_match) begin
            sl_drv = ~sl_tx[7 - sl_bit];
          end
        end else begin
          sl_bit = 0;
          sl_byte++;
          sl_drv = 1'b0;
          if (sl_byte == 2 && sl_rw && sl_match) begin
            sl_tx  = sl_reg[sl_ptr];
            sl_drv = ~sl_tx[7];
          end
        end
      end
    end else if (scl1 && sl_psda && !sda1) begin
      sl_active = 1'b1; sl_bit = 0; sl_byte = 0; sl_rose = 1'b0; sl_drv = 1'b0;
      sl_starts++;
    end else if (scl1 && !sl_psda && sda1) begin
      sl_active = 1'b0; sl_drv = 1'b0;
      sl_stops++;
    end
    sl_pscl = scl1;
    sl_psda = sda1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int         cyc;
    logic       chk_rd;
    logic [7:0] rd;
    logic       ackerr;
  } exp_t;
  exp_t q1[$];
  exp_t q2[$];

  always @(negedge clk) begin
    if (!rst && bus1.oDone) begin
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL done1_unexpected: got oDone at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("done1_cycle", cyc, e.cyc);
        chk("done1_busy_low", bus1.oBusy, 1'b0);
        chk("done1_ackerr", bus1.oAckErr, e.ackerr);
        if (e.chk_rd) chk("done1_rdata", bus1.oRData, e.rd);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus2.oDone) begin
      if (q2.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL done2_unexpected: got oDone at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("done2_cycle", cyc, e.cyc);
        chk("done2_ackerr", bus2.oAckErr, e.ackerr);
        chk("done2_rdata", bus2.oRData, e.rd);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a negedge; iStart is seen by the following posedge.
  task automatic cmd1(input logic rw, input logic [7:0] ra, input logic [7:0] wd,
                      input logic chk_rd, input logic [7:0] rd);
    exp_t e;
    bus1.iStart = 1'b1; bus1.iRw = rw; bus1.iRegAddr = ra; bus1.iWData = wd;
    e.cyc = cyc + 1 + FRAME; e.chk_rd = chk_rd; e.rd = rd; e.ackerr = 1'b0;
    q1.push_back(e);
    @(negedge clk);
    bus1.iStart = 1'b0;
    chk("busy_after_accept", bus1.oBusy, 1'b1);
  endtask

  task automatic wait_done1(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < BOUND && !seen; i++) begin
      @(negedge clk);
      if (bus1.oDone) seen = 1'b1;
    end
    chk(name, seen, 1'b1);
  endtask

  initial begin
    exp_t e2;
    logic seen2;
    int   stops0;
    bus1.iStart = 1'b0; bus1.iRw = 1'b0; bus1.iRegAddr = 8'h00; bus1.iWData = 8'h00;
    bus2.iStart = 1'b0; bus2.iRw = 1'b0; bus2.iRegAddr = 8'h00; bus2.iWData = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_scl", scl1, 1'b1);
    chk("rst_sda", sda1, 1'b1);
    chk("rst_busy", bus1.oBusy, 1'b0);
    chk("rst_done", bus1.oDone, 1'b0);
    chk("rst_ackerr", bus1.oAckErr, 1'b0);
    chk("rst_rdata", bus1.oRData, 8'h00);
    rst = 1'b0;

    // Idle 100 cycles
    repeat (100) @(negedge clk);
    chk("idle_scl", scl1, 1'b1);
    chk("idle_sda", sda1, 1'b1);
    chk("idle_busy", bus1.oBusy, 1'b0);
    chk("idle_rdata", bus1.oRData, 8'h00);
    chk("idle_no_start", sl_starts, 0);

    // Write A5 to reg 2
    cmd1(1'b0, 8'h02, 8'hA5, 1'b0, 8'h00);
    wait_done1("wr2_done_seen");
    chk("wr2_slave_reg2", sl_reg[2], 8'hA5);
    chk("wr2_slave_reg1_untouched", sl_reg[1], 8'h22);
    chk("wr2_stop_seen", sl_stops, 1);
    chk("wr2_start_seen", sl_starts, 1);

    // Write 3C to reg 1, then read reg 1
    @(negedge clk);
    cmd1(1'b0, 8'h01, 8'h3C, 1'b0, 8'h00);
    wait_done1("wr1_done_seen");
    chk("wr1_slave_reg1", sl_reg[1], 8'h3C);
    @(negedge clk);
    stops0 = sl_stops;
    cmd1(1'b1, 8'h01, 8'h00, 1'b1, 8'h3C);
    wait_done1("rd1_done_seen");
    chk("rd1_master_nack", sl_mnack, 1'b1);
    chk("rd1_stop_seen", sl_stops, stops0 + 1);
    chk("rd1_rdata_hold", bus1.oRData, 8'h3C);

    // Mis-addressed master: every ACK slot reads NACK
    @(negedge clk);
    bus2.iStart = 1'b1; bus2.iRw = 1'b0; bus2.iRegAddr = 8'h02; bus2.iWData = 8'hFF;
`ifdef I2C_MST_ACK_CHK_EN
    e2.cyc = cyc + 1 + 44 * Q; e2.ackerr = 1'b1;
`else
    e2.cyc = cyc + 1 + FRAME;  e2.ackerr = 1'b0;
`endif
    e2.chk_rd = 1'b1; e2.rd = 8'h00;
    q2.push_back(e2);
    @(negedge clk);
    bus2.iStart = 1'b0;
    chk("bad_busy_after_accept", bus2.oBusy, 1'b1);
    seen2 = 1'b0;
    for (int i = 0; i < BOUND && !seen2; i++) begin
      @(negedge clk);
      if (bus2.oDone) seen2 = 1'b1;
    end
    chk("bad_done_seen", seen2, 1'b1);
    chk("bad_slave_reg2", sl_reg[2], 8'hA5);
    chk("bad_slave_reg1", sl_reg[1], 8'h3C);

    // iStart mid-frame ignored; iStart in the oDone cycle accepted
    @(negedge clk);
    cmd1(1'b0, 8'h00, 8'h77, 1'b0, 8'h00);
    repeat (200) @(negedge clk);
    bus1.iStart = 1'b1; bus1.iRw = 1'b1; bus1.iRegAddr = 8'h03; bus1.iWData = 8'h99;
    @(negedge clk);
    bus1.iStart = 1'b0;
    wait_done1("mid_done_seen");
    cmd1(1'b0, 8'h03, 8'hC3, 1'b0, 8'h00);
    chk("mid_slave_reg0", sl_reg[0], 8'h77);
    wait_done1("back2back_done_seen");
    chk("b2b_slave_reg3", sl_reg[3], 8'hC3);

    // Reset during WDATA bit 3 (slot 22, q2)
    @(negedge clk);
    cmd1(1'b0, 8'h03, 8'h0F, 1'b0, 8'h00);
    repeat (88 * Q + 2 * Q) @(negedge clk);
    chk("pre_rst_busy", bus1.oBusy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_scl", scl1, 1'b1);
    chk("midrst_sda", sda1, 1'b1);
    chk("midrst_busy", bus1.oBusy, 1'b0);
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_reg3_unchanged", sl_reg[3], 8'hC3);
    repeat (5) @(negedge clk);
    cmd1(1'b0, 8'h03, 8'h5A, 1'b0, 8'h00);
    wait_done1("post_rst_done_seen");
    chk("post_rst_reg3", sl_reg[3], 8'h5A);

    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
